keypress_length_counter: RTL and testbench
==========================================

# keypress_length_counter

Parametrised word-length counter for the keypad entry path. It counts debounced key presses and backspaces on a prescaled sample tick, and exposes saturation and overflow status. It sits between the keypad decoder and the word-compare/display logic. It replaces the fixed 3-bit, increment-only counter with configurable width, limit, wrap mode and decrement support, all in a single clock domain.

## Interface
- CNT_W, 3: count width in bits (≥1)
- MAX_COUNT, 2**CNT_W-1: upper count limit (1..2**CNT_W-1)
- TICK_DIV, 60000: clk cycles per sample tick (≥1; 1 = tick every cycle)
- WRAP, 0: 0 = saturate at MAX_COUNT; 1 = wrap MAX_COUNT→0
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  reset, asynchronous, active-high
- key_press  in  1  level, high while a character key is held (already synchronous)
- key_back  in  1  level, high while backspace key is held (already synchronous)
- clear  in  1  synchronous clear (star key / word submit)
- count  out  CNT_W  current length
- empty  out  1  count == 0
- full  out  1  count == MAX_COUNT
- overflow  out  1  sticky; increment attempted at MAX_COUNT

## Operation
- Edge detect: inc_edge = key_press & ~press_prev; dec_edge = key_back & ~back_prev; prev regs update every posedge.
- Pending flags pend_inc and pend_dec:
  - Set on the respective edge.
  - Cleared when applied at a tick.
  - Multiple edges between ticks collapse to one.
- Prescaler: 0..TICK_DIV-1. tick = (prescaler == TICK_DIV-1); it wraps to 0 on tick. Prescaler is unaffected by clear.
- At a tick: do_inc = pend_inc | inc_edge; do_dec = pend_dec | dec_edge.
  - do_inc & do_dec: count unchanged, both pendings cleared.
  - do_inc only:
    - count < MAX_COUNT: count + 1.
    - count == MAX_COUNT, WRAP=0: hold; overflow ← 1.
    - count == MAX_COUNT, WRAP=1: count ← 0; overflow ← 1.
  - do_dec only:
    - count > 0: count − 1.
    - count == 0: hold, no flag.
- clear (highest priority below reset):
  - Sets count ← 0, overflow ← 0, pend_inc/pend_dec ← 0.
  - Edges detected in the same cycle are discarded.
  - The prev regs still update.
- Reset mid-operation: all state returns to its reset value immediately; pending presses are lost.
- empty and full are registered, consistent with count in the same cycle.

## Timing
- Reset values: count 0, empty 1, full 0, overflow 0, prescaler 0, prev regs 0, pendings 0.
- Latency:
  - Edge at posedge k that is also a tick: count updates at edge k.
  - Otherwise count updates at the first tick edge after k.
  - Worst case TICK_DIV cycles.
- A key held high produces exactly one increment. Release plus re-press is required for the next one.
- Simultaneous key_press edge and key_back edge in one tick window: net zero.
- clear and tick in the same cycle: clear wins.
- Overflow flag rises on the same edge the blocked/wrapped increment is evaluated.

## Structure
- Shared package keypad_pkg:
  - Default constants CNT_W_DEF=3 and TICK_DIV_DEF=60000.
  - Function for prescaler width: $clog2(TICK_DIV) with a minimum of 1.
- Sub-module tick_prescaler (params TICK_DIV; ports clk, reset, tick) instantiated once.
- Edge detect, pending flags and count/flag registers live in the top module.

## Test plan
Directed tests use CNT_W=3, TICK_DIV=4 unless stated.
- After reset, hold key_press high 20 cycles → exactly one increment: count=1, empty=0.
- 9 separate press pulses, each spaced ≥4 cycles, WRAP=0 → count saturates at 7; full=1 from the 7th; overflow=1 after the 8th.
- Same 9 pulses with WRAP=1 → count sequence 1..7, 0, 1; overflow=1 after the 8th pulse.
- count=3, key_press and key_back pulses within one tick window → count stays 3, no flags. A lone key_back pulse → 2. Backspace at 0 holds 0, overflow unchanged.
- Press pulse followed by clear before the tick → count=0, pending dropped, no increment at the next tick. clear coincident with a tick → count=0.
- TICK_DIV=1: each press pulse increments on the detecting edge. Async reset asserted between clock edges → count=0, empty=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad entry path.
package keypad_pkg;

    localparam int unsigned CNT_W_DEF    = 3;
    localparam int unsigned TICK_DIV_DEF = 60000;

    // Prescaler register width; a divide-by-1 still needs one bit.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle sample tick every TICK_DIV clocks.
module tick_prescaler
    import keypad_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic TICK_RST = (TICK_DIV == 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    // tick_q is precomputed from the next prescaler value so it is high
    // exactly while presc_q == TICK_DIV-1.
    always_comb begin
        presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= TICK_RST;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypress_length_counter.sv
// Word-length counter: edge-detected key presses/backspaces applied on a
// prescaled sample tick, with saturate or wrap at MAX_COUNT and sticky overflow.
module keypress_length_counter
    import keypad_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_COUNT = (1 << CNT_W) - 1,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned WRAP      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_press,
    input  logic             key_back,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic             press_prev_q, press_prev_d;
    logic             back_prev_q,  back_prev_d;
    logic             pend_inc_q,   pend_inc_d;
    logic             pend_dec_q,   pend_dec_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             empty_q,      empty_d;
    logic             full_q,       full_d;
    logic             overflow_q,   overflow_d;
    logic             inc_edge, dec_edge, do_inc, do_dec;

    always_comb begin
        press_prev_d = key_press;
        back_prev_d  = key_back;
        inc_edge     = key_press & ~press_prev_q;
        dec_edge     = key_back  & ~back_prev_q;
        do_inc       = pend_inc_q | inc_edge;
        do_dec       = pend_dec_q | dec_edge;
        pend_inc_d   = do_inc;
        pend_dec_d   = do_dec;
        count_d      = count_q;
        overflow_d   = overflow_q;

        // clear drops same-cycle edges and overrides a coincident tick
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
            pend_inc_d = 1'b0;
            pend_dec_d = 1'b0;
        end else if (tick) begin
            pend_inc_d = 1'b0;
            pend_dec_d = 1'b0;
            if (do_inc && !do_dec) begin
                if (count_q == MAX_C) begin
                    overflow_d = 1'b1;
                    count_d    = (WRAP != 0) ? '0 : count_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (do_dec && !do_inc) begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == MAX_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_prev_q <= 1'b0;
            back_prev_q  <= 1'b0;
            pend_inc_q   <= 1'b0;
            pend_dec_q   <= 1'b0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            press_prev_q <= press_prev_d;
            back_prev_q  <= back_prev_d;
            pend_inc_q   <= pend_inc_d;
            pend_dec_q   <= pend_dec_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
        end
    end

    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypress_length_counter.sv
// Three counters (saturating /4, wrapping /4, saturating /1) share one stimulus
// stream and are checked every cycle against a per-configuration reference.
module tb_keypress_length_counter;

    localparam int unsigned CW = 3;
    localparam int MAXC = 7;
    localparam int NM   = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_press, key_back, clear;
    logic chk_en;

    logic [CW-1:0] cnt0, cnt1, cnt2;
    logic e0, e1, e2, f0, f1, f2, o0, o1, o2;

    int vectors    = 0;
    int miscompares = 0;

    int m_cnt [NM];
    bit m_ovf [NM];
    bit m_pi  [NM];
    bit m_pd  [NM];
    int m_cyc [NM];
    bit prev_p, prev_b;

    always #5 clk = ~clk;

    keypress_length_counter #(.CNT_W(CW), .MAX_COUNT(MAXC), .TICK_DIV(4), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .key_press(key_press), .key_back(key_back), .clear(clear),
        .count(cnt0), .empty(e0), .full(f0), .overflow(o0));

    keypress_length_counter #(.CNT_W(CW), .MAX_COUNT(MAXC), .TICK_DIV(4), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .key_press(key_press), .key_back(key_back), .clear(clear),
        .count(cnt1), .empty(e1), .full(f1), .overflow(o1));

    keypress_length_counter #(.CNT_W(CW), .MAX_COUNT(MAXC), .TICK_DIV(1), .WRAP(0)) dut_fast (
        .clk(clk), .reset(reset), .key_press(key_press), .key_back(key_back), .clear(clear),
        .count(cnt2), .empty(e2), .full(f2), .overflow(o2));

    function automatic int td_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit wrap_of(input int k);
        return (k == 1);
    endfunction

    function automatic int dut_cnt(input int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int dut_empty(input int k);
        case (k)
            0: return int'(e0);
            1: return int'(e1);
            default: return int'(e2);
        endcase
    endfunction

    function automatic int dut_full(input int k);
        case (k)
            0: return int'(f0);
            1: return int'(f1);
            default: return int'(f2);
        endcase
    endfunction

    function automatic int dut_ovf(input int k);
        case (k)
            0: return int'(o0);
            1: return int'(o1);
            default: return int'(o2);
        endcase
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NM; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_pi[k] = 0; m_pd[k] = 0; m_cyc[k] = 0;
        end
        prev_p = 0;
        prev_b = 0;
    endtask

    // One clock edge of behaviour: ticks fall on every TICK_DIV-th edge after reset.
    task automatic model_step();
        bit pe, be, tk;
        pe = key_press && !prev_p;
        be = key_back && !prev_b;
        for (int k = 0; k < NM; k++) begin
            tk = (m_cyc[k] % td_of(k)) == (td_of(k) - 1);
            m_cyc[k]++;
            if (clear) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_pi[k] = 0; m_pd[k] = 0;
            end else begin
                m_pi[k] = m_pi[k] | pe;
                m_pd[k] = m_pd[k] | be;
                if (tk) begin
                    if (m_pi[k] && !m_pd[k]) begin
                        if (m_cnt[k] == MAXC) begin
                            m_ovf[k] = 1;
                            if (wrap_of(k)) m_cnt[k] = 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end else if (m_pd[k] && !m_pi[k]) begin
                        if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                    end
                    m_pi[k] = 0;
                    m_pd[k] = 0;
                end
            end
        end
        prev_p = key_press;
        prev_b = key_back;
    endtask

    // Per-cycle compare against the reference, 1 time unit after each edge.
    always @(posedge clk) begin
        if (!reset) model_step();
        #1;
        if (chk_en) begin
            for (int k = 0; k < NM; k++) begin
                chk("count", k, dut_cnt(k), m_cnt[k]);
                chk("empty", k, dut_empty(k), int'(m_cnt[k] == 0));
                chk("full", k, dut_full(k), int'(m_cnt[k] == MAXC));
                chk("overflow", k, dut_ovf(k), int'(m_ovf[k]));
            end
        end
    end

    // Reset asserted mid-cycle must take effect without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < NM; k++) begin
            chk("async_rst_count", k, dut_cnt(k), 0);
            chk("async_rst_empty", k, dut_empty(k), 1);
            chk("async_rst_ovf", k, dut_ovf(k), 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press_pulse();
        @(negedge clk); key_press = 1'b1;
        @(negedge clk); key_press = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic back_pulse();
        @(negedge clk); key_back = 1'b1;
        @(negedge clk); key_back = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_all_count(input string name, input int exp);
        for (int k = 0; k < NM; k++) chk(name, k, dut_cnt(k), exp);
    endtask

    initial begin
        reset = 1'b1; key_press = 1'b0; key_back = 1'b0; clear = 1'b0;
        chk_en = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Held key yields exactly one increment.
        @(negedge clk); key_press = 1'b1;
        repeat (20) @(negedge clk);
        chk_all_count("hold_once", 1);
        for (int k = 0; k < NM; k++) chk("hold_empty", k, dut_empty(k), 0);
        key_press = 1'b0;
        repeat (5) @(negedge clk);

        // Nine pulses: saturate vs wrap.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            press_pulse();
            chk("sat_seq", 0, dut_cnt(0), (i > 7) ? 7 : i);
            chk("sat_full", 0, dut_full(0), int'(i >= 7));
            chk("sat_ovf", 0, dut_ovf(0), int'(i >= 8));
            chk("wrap_seq", 1, dut_cnt(1), (i <= 7) ? i : i - 8);
            chk("wrap_ovf", 1, dut_ovf(1), int'(i >= 8));
            chk("fast_seq", 2, dut_cnt(2), (i > 7) ? 7 : i);
        end

        // Simultaneous press/back is net zero; lone back decrements.
        do_reset();
        repeat (3) press_pulse();
        chk_all_count("pre_both", 3);
        @(negedge clk); key_press = 1'b1; key_back = 1'b1;
        @(negedge clk); key_press = 1'b0; key_back = 1'b0;
        repeat (5) @(negedge clk);
        chk_all_count("both_net0", 3);
        back_pulse();
        chk_all_count("back_one", 2);

        // Backspace at zero holds.
        do_reset();
        back_pulse();
        chk_all_count("back_at0", 0);
        for (int k = 0; k < NM; k++) chk("back_at0_ovf", k, dut_ovf(k), 0);

        // Press followed by clear: pending dropped.
        do_reset();
        repeat (2) press_pulse();
        @(negedge clk); key_press = 1'b1;
        @(negedge clk); key_press = 1'b0; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (6) @(negedge clk);
        chk_all_count("clear_drop", 0);

        // Clear held across a tick.
        press_pulse();
        @(negedge clk); clear = 1'b1;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk_all_count("clear_tick", 0);

        // Divide-by-1 counter updates on the detecting edge.
        do_reset();
        @(negedge clk); key_press = 1'b1;
        @(posedge clk); #2;
        chk("fast_same_edge", 2, dut_cnt(2), 1);
        @(negedge clk); key_press = 1'b0;
        repeat (4) @(negedge clk);

        // Randomised traffic, including occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) key_press = ~key_press;
            if ($urandom_range(0, 4) == 0) key_back  = ~key_back;
            clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 3));
                reset = 1'b1;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
        end
        key_press = 1'b0; key_back = 1'b0; clear = 1'b0;
        repeat (6) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
